// File: rtl/dsp38_pkg.sv
// Shared DSP38 definitions: feedback codes, port widths and the sequencer FSM encoding.
package dsp38_pkg;

    localparam logic [2:0] FB_ACC = 3'b000;
    localparam logic [2:0] FB_MUL = 3'b001;

    localparam int unsigned A_W = 20;
    localparam int unsigned B_W = 18;
    localparam int unsigned Z_W = 38;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_e;

endpackage

// File: rtl/dsp38_fir_delay_line.sv
// Sample delay line for the FIR sequencer: shifts one sample in per enable,
// with a tap-indexed read port (out-of-range taps read as 0).
module dsp38_fir_delay_line
    import dsp38_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           SHIFT_EN,
    input  logic [B_W-1:0] SHIFT_DATA,
    input  logic [3:0]     RD_ADDR,
    output logic [B_W-1:0] RD_DATA
);

    logic [B_W-1:0] taps_q [NUM_TAPS];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                taps_q[i] <= '0;
            end
        end else if (SHIFT_EN) begin
            taps_q[0] <= SHIFT_DATA;
            for (int i = 1; i < int'(NUM_TAPS); i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    always_comb begin
        RD_DATA = '0;
        for (int i = 0; i < int'(NUM_TAPS); i++) begin
            if (RD_ADDR == 4'(i)) begin
                RD_DATA = taps_q[i];
            end
        end
    end

endmodule

// File: rtl/dsp38_fir_sequencer.sv
// Control stage for a single DSP38 MAC: feeds one tap per cycle from the delay
// line and coefficient table, then captures the settled sum onto an output stream.
module dsp38_fir_sequencer
    import dsp38_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [B_W-1:0] S_DATA,
    input  logic           S_VALID,
    output logic           S_READY,
    input  logic           COEFF_WE,
    input  logic [3:0]     COEFF_ADDR,
    input  logic [A_W-1:0] COEFF_WDATA,
    output logic [A_W-1:0] DSP_A,
    output logic [B_W-1:0] DSP_B,
    output logic [2:0]     DSP_FEEDBACK,
    output logic           DSP_LOAD_ACC,
    input  logic [Z_W-1:0] DSP_Z,
    output logic [Z_W-1:0] M_DATA,
    output logic           M_VALID,
    input  logic           M_READY,
    output logic           BUSY
);

    localparam logic [3:0] LAST_TAP   = 4'(NUM_TAPS - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(PIPE_LAT - 1);

    state_e         state_q;
    logic [3:0]     tap_q;
    logic [2:0]     drain_q;
    logic [Z_W-1:0] m_data_q;
    logic           m_valid_q;
    logic           s_ready_q;
    logic           busy_q;

    logic [A_W-1:0] coeff_q [NUM_TAPS];
    logic [A_W-1:0] coeff_rd;
    logic [B_W-1:0] delay_rd;
    logic           accept;

    // s_ready_q is only ever set while the FSM sits in IDLE.
    assign accept = S_VALID && s_ready_q;

    dsp38_fir_delay_line #(
        .NUM_TAPS (NUM_TAPS)
    ) u_delay_line (
        .CLK        (CLK),
        .RESET      (RESET),
        .SHIFT_EN   (accept),
        .SHIFT_DATA (S_DATA),
        .RD_ADDR    (tap_q),
        .RD_DATA    (delay_rd)
    );

    // Writes land at the clock edge, so a same-cycle MAC read still sees the old value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                coeff_q[i] <= '0;
            end
        end else if (COEFF_WE) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                if (COEFF_ADDR == 4'(i)) begin
                    coeff_q[i] <= COEFF_WDATA;
                end
            end
        end
    end

    always_comb begin
        coeff_rd = '0;
        for (int i = 0; i < int'(NUM_TAPS); i++) begin
            if (tap_q == 4'(i)) begin
                coeff_rd = coeff_q[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            drain_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= MAC;
                        tap_q     <= '0;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        s_ready_q <= 1'b1;
                    end
                end
                MAC: begin
                    if (tap_q == LAST_TAP) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end else begin
                        tap_q <= tap_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        state_q   <= OUT;
                        m_data_q  <= DSP_Z;
                        m_valid_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                OUT: begin
                    if (M_READY) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // DSP inputs are decoded from registered state; DSP38 registers them itself.
    always_comb begin
        DSP_A        = '0;
        DSP_B        = '0;
        DSP_FEEDBACK = FB_ACC;
        DSP_LOAD_ACC = 1'b0;
        if (state_q == MAC) begin
            DSP_A        = coeff_rd;
            DSP_B        = delay_rd;
            DSP_LOAD_ACC = 1'b1;
            DSP_FEEDBACK = (tap_q == 4'd0) ? FB_MUL : FB_ACC;
        end
    end

    assign S_READY = s_ready_q;
    assign M_DATA  = m_data_q;
    assign M_VALID = m_valid_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_dsp38_fir_sequencer.sv
// Directed bench for dsp38_fir_sequencer paired with a small unsigned DSP38 MAC model.
module tb_dsp38_fir_sequencer;
    import dsp38_pkg::*;

    logic        CLK;
    logic        RESET;
    logic [17:0] S_DATA;
    logic        S_VALID;
    logic        S_READY;
    logic        COEFF_WE;
    logic [3:0]  COEFF_ADDR;
    logic [19:0] COEFF_WDATA;
    logic [19:0] DSP_A;
    logic [17:0] DSP_B;
    logic [2:0]  DSP_FEEDBACK;
    logic        DSP_LOAD_ACC;
    logic [37:0] DSP_Z;
    logic [37:0] M_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic        BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    dsp38_fir_sequencer #(
        .NUM_TAPS (4),
        .PIPE_LAT (2)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .S_DATA       (S_DATA),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .COEFF_WE     (COEFF_WE),
        .COEFF_ADDR   (COEFF_ADDR),
        .COEFF_WDATA  (COEFF_WDATA),
        .DSP_A        (DSP_A),
        .DSP_B        (DSP_B),
        .DSP_FEEDBACK (DSP_FEEDBACK),
        .DSP_LOAD_ACC (DSP_LOAD_ACC),
        .DSP_Z        (DSP_Z),
        .M_DATA       (M_DATA),
        .M_VALID      (M_VALID),
        .M_READY      (M_READY),
        .BUSY         (BUSY)
    );

    // DSP38 model: input registers, then accumulator; Z is the unregistered accumulator.
    logic [19:0] a_r;
    logic [17:0] b_r;
    logic [2:0]  fb_r;
    logic        ld_r;
    logic [37:0] acc;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_r  <= '0;
            b_r  <= '0;
            fb_r <= '0;
            ld_r <= 1'b0;
            acc  <= '0;
        end else begin
            a_r  <= DSP_A;
            b_r  <= DSP_B;
            fb_r <= DSP_FEEDBACK;
            ld_r <= DSP_LOAD_ACC;
            if (ld_r) begin
                acc <= ((fb_r == FB_MUL) ? 38'd0 : acc) + 38'(a_r) * 38'(b_r);
            end
        end
    end

    assign DSP_Z = acc;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_coeff(input logic [3:0] addr, input logic [19:0] data);
        COEFF_WE    = 1'b1;
        COEFF_ADDR  = addr;
        COEFF_WDATA = data;
        tick();
        COEFF_WE    = 1'b0;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    // Returns in the first MAC cycle (cycle 1 after the accept).
    task automatic offer(input logic [17:0] d);
        int n = 0;
        S_DATA  = d;
        S_VALID = 1'b1;
        while (!S_READY && n < 100) begin
            tick();
            n++;
        end
        check("s_ready_wait", S_READY, 1);
        tick();
        S_VALID = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [37:0] exp, input int exp_lat);
        int lat = 1;
        while (!M_VALID && lat < 100) begin
            tick();
            lat++;
        end
        check(tag, M_DATA, exp);
        if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
        M_READY = 1'b1;
        tick();
        M_READY = 1'b0;
    endtask

    initial begin
        logic [37:0] exp_ones [5];
        int bad;
        int seen;
        int both;
        int acc_cyc [$];

        RESET       = 1'b1;
        S_DATA      = '0;
        S_VALID     = 1'b0;
        COEFF_WE    = 1'b0;
        COEFF_ADDR  = '0;
        COEFF_WDATA = '0;
        M_READY     = 1'b0;
        #3;
        check("rst_s_ready", S_READY, 0);
        check("rst_m_valid", M_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_m_data", M_DATA, 0);
        check("rst_load_acc", DSP_LOAD_ACC, 0);
        check("rst_dsp_a", DSP_A, 0);
        tick();
        tick();
        RESET = 1'b0;
        tick();
        check("idle_s_ready", S_READY, 1);

        // Coeffs {1,2,3,4}, samples 10,20,30.
        write_coeff(4'd0, 20'd1);
        write_coeff(4'd1, 20'd2);
        write_coeff(4'd2, 20'd3);
        write_coeff(4'd3, 20'd4);
        offer(18'd10);
        collect("fir_a0", 38'd10, 7);
        offer(18'd20);
        collect("fir_a1", 38'd40, 7);
        offer(18'd30);
        collect("fir_a2", 38'd100, 7);

        // Coeffs all 1, five samples of 5: running fill of the delay line.
        pulse_reset();
        for (int i = 0; i < 4; i++) write_coeff(4'(i), 20'd1);
        exp_ones[0] = 38'd5;
        exp_ones[1] = 38'd10;
        exp_ones[2] = 38'd15;
        exp_ones[3] = 38'd20;
        exp_ones[4] = 38'd20;
        for (int i = 0; i < 5; i++) begin
            offer(18'd5);
            collect($sformatf("ones_%0d", i), exp_ones[i], 7);
        end

        // Output back-pressure with a sample offered during OUT.
        offer(18'd5);
        seen = 1;
        while (!M_VALID && seen < 100) begin
            tick();
            seen++;
        end
        check("hold_first", M_DATA, 20);
        S_DATA  = 18'd9;
        S_VALID = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (M_DATA != 38'd20 || S_READY || !M_VALID) bad++;
            tick();
        end
        check("hold_bad_cycles", bad, 0);
        M_READY = 1'b1;
        tick();
        M_READY = 1'b0;
        check("rel_busy", BUSY, 0);
        check("rel_m_valid", M_VALID, 0);
        check("rel_s_ready", S_READY, 1);
        tick();
        S_VALID = 1'b0;
        check("pend_busy", BUSY, 1);
        collect("pend_out", 38'd24, 7);

        // Tap drive, then reset in MAC k=2.
        offer(18'd7);
        check("k0_dsp_a", DSP_A, 1);
        check("k0_dsp_b", DSP_B, 7);
        check("k0_fb", DSP_FEEDBACK, 3'b001);
        check("k0_ld", DSP_LOAD_ACC, 1);
        tick();
        check("k1_dsp_b", DSP_B, 9);
        check("k1_fb", DSP_FEEDBACK, 3'b000);
        tick();
        RESET = 1'b1;
        #1;
        check("mrst_m_valid", M_VALID, 0);
        check("mrst_busy", BUSY, 0);
        check("mrst_s_ready", S_READY, 0);
        check("mrst_ld", DSP_LOAD_ACC, 0);
        check("mrst_dsp_b", DSP_B, 0);
        check("mrst_m_data", M_DATA, 0);
        tick();
        RESET = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (M_VALID) seen++;
            tick();
        end
        check("mrst_no_valid", seen, 0);
        write_coeff(4'd0, 20'd3);
        offer(18'd7);
        collect("post_reset", 38'd21, 7);

        // Out-of-range coefficient write, then a write racing the MAC read.
        write_coeff(4'd0, 20'd1);
        write_coeff(4'd1, 20'd2);
        write_coeff(4'd2, 20'd3);
        write_coeff(4'd3, 20'd4);
        write_coeff(4'd9, 20'd555);
        offer(18'd2);
        collect("addr9_ignored", 38'd16, 7);
        offer(18'd3);
        tick();
        COEFF_WE    = 1'b1;
        COEFF_ADDR  = 4'd1;
        COEFF_WDATA = 20'd100;
        check("race_dsp_a", DSP_A, 2);
        tick();
        COEFF_WE = 1'b0;
        collect("coeff_old", 38'd28, 0);
        offer(18'd1);
        collect("coeff_new", 38'd335, 7);

        // Back-to-back samples with the output always ready.
        both    = 0;
        S_DATA  = 18'd1;
        S_VALID = 1'b1;
        M_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (S_READY) acc_cyc.push_back(cyc);
            if (BUSY && S_READY) both++;
            tick();
        end
        S_VALID = 1'b0;
        M_READY = 1'b0;
        check("b2b_both_high", both, 0);
        check("b2b_accepts", acc_cyc.size(), 5);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check($sformatf("b2b_gap_%0d", i), acc_cyc[i] - acc_cyc[i-1], 8);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
